// File: rtl/fft_pkg.sv
// fft_pkg
// Shared definitions for the FFT input-side blocks.
//   FFT_DEPTH / FFT_ADDR_W / FFT_DATA_W : default frame geometry.
//   LOAD / HOLD                         : loader FSM state encoding.
//   bitrev(addr, addr_w)                : reverses the low addr_w bits of addr.
package fft_pkg;

    localparam int FFT_DEPTH  = 16;
    localparam int FFT_ADDR_W = 4;
    localparam int FFT_DATA_W = 32;

    localparam logic LOAD = 1'b0;
    localparam logic HOLD = 1'b1;

    // Widest address the reverser handles; callers pass their real width.
    localparam int BITREV_MAX_W = 16;

    // Reverse the whole BITREV_MAX_W-bit field, then shift the reversed
    // low-order addr_w bits back down to bit 0. With addr_w constant at the
    // call site this reduces to pure wiring.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] addr,
        input int                      addr_w
    );
        logic [BITREV_MAX_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            rev[i] = addr[BITREV_MAX_W-1-i];
        end
        return rev >> (BITREV_MAX_W - addr_w);
    endfunction

endpackage

// File: rtl/fft_input_loader.sv
// fft_input_loader
// Streams complex samples into the FFT input buffer at bit-reversed (or
// natural) addresses and holds the completed frame until the butterfly
// engine reports compute_done.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_valid/s_ready     upstream handshake
//   s_data, s_last      upstream sample and end-of-frame marker
//   flush               synchronous abort of partial or held frame
//   compute_done        releases a held frame
//   write_enable        buffer write strobe (1 cycle after handshake)
//   write_address       buffer write address
//   data_in             buffer write data
//   frame_ready         full frame resident in buffer
//   frame_err           one-cycle framing error pulse
//   frame_cnt           completed frames, wraps at 255
//
// State table:
//   state | meaning
//   LOAD  | accepting samples, writing them into the buffer
//   HOLD  | full frame resident, waiting for compute_done
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int DEPTH       = FFT_DEPTH,
    parameter int ADDR_W      = FFT_ADDR_W,
    parameter int DATA_W      = FFT_DATA_W,
    parameter int BIT_REVERSE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              flush,
    input  logic              compute_done,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] data_in,
    output logic              frame_ready,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic              state;
    logic              state_next;
    logic [ADDR_W-1:0] count;
    logic              handshake;
    logic              accept;
    logic              final_sample;
    logic [ADDR_W-1:0] target_addr;

    assign handshake    = s_valid && s_ready;
    // A handshake coinciding with flush is dropped entirely.
    assign accept       = handshake && !flush;
    assign final_sample = (count == LAST_IDX);

    always_comb begin
        target_addr = count;
        if (BIT_REVERSE != 0) begin
            target_addr = ADDR_W'(bitrev(BITREV_MAX_W'(count), ADDR_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD: if (handshake && final_sample) state_next = HOLD;
                HOLD: if (compute_done)              state_next = LOAD;
                default:                             state_next = LOAD;
            endcase
        end
    end

    always_comb begin
        s_ready     = (state == LOAD);
        frame_ready = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count         <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            data_in       <= '0;
            frame_err     <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            write_enable <= accept;
            frame_err    <= 1'b0;

            if (flush) begin
                count <= '0;
            end else if (accept) begin
                write_address <= target_addr;
                data_in       <= s_data;

                if (final_sample) begin
                    count     <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                    // Frame still completes without s_last, but flag it.
                    frame_err <= !s_last;
                end else if (s_last) begin
                    // Short frame: the sample was written, the frame is dropped.
                    count     <= '0;
                    frame_err <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule
